mul_div_unit: RTL and testbench

- Multi-cycle signed multiply/divide engine in the Mini-SRC datapath.
- Consumes the Y-register value and the current bus value.
- Produces the 64-bit result captured into Zhigh/Zlow, which drive the bus on later control steps.
- Sequenced by the control unit with a start/done handshake; one iteration per clock.

---
 rtl/mul_div_unit.sv | 164 ++++++++++++++++
 tb/tb_mul_div_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring) engine.
// One iteration per clock, fixed 32-iteration latency, start/done handshake.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] z_high,
    output logic [WIDTH-1:0] z_low,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int              CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_count;
    logic             r_op;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_q;
    logic             r_q_m1;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_a;
    logic             r_sign_a;
    logic             r_sign_b;
    logic             r_b_zero;
    logic [WIDTH-1:0] r_z_high;
    logic [WIDTH-1:0] r_z_low;
    logic             r_div_by_zero;

    logic [WIDTH:0]   w_acc_ext;
    logic [WIDTH:0]   w_m_ext;
    logic [WIDTH:0]   w_booth_sum;
    logic [WIDTH-1:0] w_mul_acc;
    logic [WIDTH-1:0] w_mul_q;
    logic [WIDTH:0]   w_div_shift;
    logic             w_div_fits;
    logic [WIDTH-1:0] w_div_rem;
    logic [WIDTH-1:0] w_div_quo;
    logic [WIDTH-1:0] w_quo_signed;
    logic [WIDTH-1:0] w_rem_signed;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (clear) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // NOTE: defaults first in always_comb so no path leaves a signal unassigned (no latch).
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (r_count == LAST) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Booth step: add/subtract in WIDTH+1 bits so a -2^(WIDTH-1) multiplicand cannot overflow.
    always_comb begin
        w_acc_ext = {r_acc[WIDTH-1], r_acc};
        w_m_ext   = {r_m[WIDTH-1], r_m};
        case ({r_q[0], r_q_m1})
            2'b01:   w_booth_sum = w_acc_ext + w_m_ext;
            2'b10:   w_booth_sum = w_acc_ext - w_m_ext;
            default: w_booth_sum = w_acc_ext;
        endcase
    end

    assign w_mul_acc = w_booth_sum[WIDTH:1];
    assign w_mul_q   = {w_booth_sum[0], r_q[WIDTH-1:1]};

    // Restoring step on magnitudes: r_acc is the partial remainder, r_q shifts dividend out / quotient in.
    assign w_div_shift  = {r_acc, r_q[WIDTH-1]};
    assign w_div_fits   = (w_div_shift >= {1'b0, r_m});
    assign w_div_rem    = w_div_fits ? WIDTH'(w_div_shift - {1'b0, r_m}) : w_div_shift[WIDTH-1:0];
    assign w_div_quo    = {r_q[WIDTH-2:0], w_div_fits};
    assign w_quo_signed = (r_sign_a ^ r_sign_b) ? -w_div_quo : w_div_quo;
    assign w_rem_signed = r_sign_a ? -w_div_rem : w_div_rem;

    assign w_abs_a = operand_a[WIDTH-1] ? -operand_a : operand_a;
    assign w_abs_b = operand_b[WIDTH-1] ? -operand_b : operand_b;

    always_ff @(posedge clock) begin
        if (clear) begin
            r_count       <= '0;
            r_op          <= 1'b0;
            r_acc         <= '0;
            r_q           <= '0;
            r_q_m1        <= 1'b0;
            r_m           <= '0;
            r_a           <= '0;
            r_sign_a      <= 1'b0;
            r_sign_b      <= 1'b0;
            r_b_zero      <= 1'b0;
            r_z_high      <= '0;
            r_z_low       <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op     <= op;
                        r_count  <= '0;
                        r_acc    <= '0;
                        r_q_m1   <= 1'b0;
                        r_a      <= operand_a;
                        r_sign_a <= operand_a[WIDTH-1];
                        r_sign_b <= operand_b[WIDTH-1];
                        r_b_zero <= (operand_b == '0);
                        if (op) begin
                            r_q <= w_abs_a;
                            r_m <= w_abs_b;
                        end else begin
                            r_q <= operand_b;
                            r_m <= operand_a;
                        end
                    end
                end
                S_RUN: begin
                    r_count <= r_count + 1'b1;
                    r_acc   <= r_op ? w_div_rem : w_mul_acc;
                    r_q     <= r_op ? w_div_quo : w_mul_q;
                    r_q_m1  <= r_q[0];
                    if (r_count == LAST) begin
                        if (!r_op) begin
                            r_z_high      <= w_mul_acc;
                            r_z_low       <= w_mul_q;
                            r_div_by_zero <= 1'b0;
                        end else if (r_b_zero) begin
                            r_z_high      <= r_a;
                            r_z_low       <= '1;
                            r_div_by_zero <= 1'b1;
                        end else begin
                            r_z_high      <= w_rem_signed;
                            r_z_low       <= w_quo_signed;
                            r_div_by_zero <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign z_high      = r_z_high;
    assign z_low       = r_z_low;
    assign div_by_zero = r_div_by_zero;
    assign busy        = (r_state == S_RUN);
    assign done        = (r_state == S_DONE);

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: MUL/DIV vectors, latency,
// special cases, mid-run input changes and mid-run clear.
module tb_mul_div_unit;

    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic        op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] z_high;
    logic [31:0] z_low;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int n_assert = 0;
    int n_fail   = 0;
    int lat;
    int busy_cnt;
    int done_cnt;

    mul_div_unit #(.WIDTH(32)) dut (
        .clock      (clock),
        .clear      (clear),
        .start      (start),
        .op         (op),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .z_high     (z_high),
        .z_low      (z_low),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Launch one operation and wait (bounded) for done; lat counts edges after E0.
    task automatic launch(input logic i_op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        start = 1'b1; op = i_op; operand_a = a; operand_b = b;
        @(posedge clock); #1;
        start = 1'b0;
        lat = 0;
        busy_cnt = busy ? 1 : 0;
    endtask

    task automatic wait_done();
        while (!done && lat < 40) begin
            @(posedge clock); #1;
            lat++;
            if (busy) busy_cnt++;
        end
    endtask

    task automatic run_op(input logic i_op, input logic [31:0] a, input logic [31:0] b);
        launch(i_op, a, b);
        wait_done();
    endtask

    task automatic done_falls(input string tag);
        @(posedge clock); #1;
        check(tag, {63'd0, done}, 64'd0);
    endtask

    initial begin
        clear = 1'b1; start = 1'b0; op = 1'b0; operand_a = '0; operand_b = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_z",    {z_high, z_low}, 64'd0);
        check("reset_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
        @(negedge clock); clear = 1'b0;

        // MUL 6 x 7 with latency and busy-length checks
        run_op(1'b0, 32'd6, 32'd7);
        check("mul_6x7_latency", 64'(lat), 64'd32);
        check("mul_6x7_busy_cycles", 64'(busy_cnt), 64'd32);
        check("mul_6x7", {z_high, z_low}, 64'h00000000_0000002A);
        done_falls("mul_6x7_done_pulse");

        run_op(1'b0, 32'hFFFFFFFD, 32'd7);
        check("mul_m3x7", {z_high, z_low}, 64'hFFFFFFFF_FFFFFFEB);
        done_falls("mul_m3x7_done_pulse");

        run_op(1'b0, 32'h80000000, 32'h80000000);
        check("mul_min_x_min", {z_high, z_low}, 64'h40000000_00000000);
        done_falls("mul_min_done_pulse");

        run_op(1'b1, 32'hFFFFFFEF, 32'd5);
        check("div_m17_5", {z_high, z_low}, 64'hFFFFFFFE_FFFFFFFD);
        check("div_m17_5_dbz", {63'd0, div_by_zero}, 64'd0);
        done_falls("div_m17_5_done_pulse");

        run_op(1'b1, 32'd17, 32'hFFFFFFFB);
        check("div_17_m5", {z_high, z_low}, 64'h00000002_FFFFFFFD);
        check("div_17_m5_dbz", {63'd0, div_by_zero}, 64'd0);
        done_falls("div_17_m5_done_pulse");

        // Divide by zero: same latency, forced result, flag held until next completion
        run_op(1'b1, 32'd100, 32'd0);
        check("div0_latency", 64'(lat), 64'd32);
        check("div0_result", {z_high, z_low}, 64'h00000064_FFFFFFFF);
        check("div0_flag", {63'd0, div_by_zero}, 64'd1);
        done_falls("div0_done_pulse");
        check("div0_flag_held", {63'd0, div_by_zero}, 64'd1);

        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF);
        check("div_min_m1", {z_high, z_low}, 64'h00000000_80000000);
        check("div_min_m1_dbz_cleared", {63'd0, div_by_zero}, 64'd0);
        done_falls("div_min_done_pulse");

        // Operand and start changes mid-run must not disturb the latched operation
        launch(1'b0, 32'd5, 32'd5);
        repeat (3) begin @(posedge clock); #1; lat++; end
        @(negedge clock);
        operand_a = 32'd123; operand_b = 32'd77; op = 1'b1; start = 1'b1;
        @(posedge clock); #1; lat++;
        start = 1'b0;
        wait_done();
        check("midrun_latency", 64'(lat), 64'd32);
        check("midrun_result", {z_high, z_low}, 64'h00000000_00000019);
        done_falls("midrun_done_pulse");
        check("midrun_no_restart", {62'd0, busy, done}, 64'd0);

        // Clear at RUN cycle 10 aborts with all outputs zero and no later done
        launch(1'b0, 32'd6, 32'd7);
        repeat (9) @(posedge clock);
        @(negedge clock); clear = 1'b1;
        @(posedge clock); #1;
        check("clear_z", {z_high, z_low}, 64'd0);
        check("clear_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
        @(negedge clock); clear = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (done || busy) done_cnt++;
        end
        check("clear_no_done", 64'(done_cnt), 64'd0);

        run_op(1'b1, 32'd9, 32'd2);
        check("div_9_2_latency", 64'(lat), 64'd32);
        check("div_9_2", {z_high, z_low}, 64'h00000001_00000004);
        done_falls("div_9_2_done_pulse");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
